// File: rtl/traffic_lights_cfg_arbiter.sv
// Round-robin arbiter that accepts whole configuration jobs from NUM_REQ requesters
// and expands each winning job into the single-cycle command sequence of traffic_lights.
// RUN job: STANDBY, SET_GREEN, SET_RED, SET_YELLOW, ON. OFF job: OFF.
// Optional build macro TL_CFG_RANGE_CHECK_EN: RUN jobs with a time of 0 or above MAX_TIME
// are consumed without issuing commands and flagged with a one-cycle err_o pulse.
module traffic_lights_cfg_arbiter #(
    parameter int unsigned       NUM_REQ  = 2,
    parameter int unsigned       TIME_W   = 16,
    parameter logic [TIME_W-1:0] MAX_TIME = TIME_W'(1000)
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ-1:0]         req_op_i,
    input  logic [NUM_REQ*TIME_W-1:0]  req_green_i,
    input  logic [NUM_REQ*TIME_W-1:0]  req_red_i,
    input  logic [NUM_REQ*TIME_W-1:0]  req_yellow_i,
    output logic [2:0]                 cmd_type_o,
    output logic                       cmd_valid_o,
    output logic [TIME_W-1:0]          cmd_data_o,
    output logic                       busy_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] CmdOn     = 3'd0;
    localparam logic [2:0] CmdOff    = 3'd1;
    localparam logic [2:0] CmdStby   = 3'd2;
    localparam logic [2:0] CmdGreen  = 3'd3;
    localparam logic [2:0] CmdRed    = 3'd4;
    localparam logic [2:0] CmdYellow = 3'd5;

    typedef enum logic [2:0] {
        StIdle,
        StStby,
        StGrn,
        StRed,
        StYel,
        StOn,
        StOff
    } state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      rr_q, rr_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic [TIME_W-1:0]   green_q, green_d;
    logic [TIME_W-1:0]   red_q, red_d;
    logic [TIME_W-1:0]   yellow_q, yellow_d;
    logic                err_q, err_d;

    logic                found;
    int unsigned         win_idx;
    int unsigned         idx;
    logic [IdW-1:0]      win_id;
    logic [IdW-1:0]      next_rr;
    logic [TIME_W-1:0]   win_green;
    logic [TIME_W-1:0]   win_red;
    logic [TIME_W-1:0]   win_yellow;
    logic                range_bad;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid_i[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign win_id     = IdW'(win_idx);
    assign next_rr    = (win_idx + 1 == NUM_REQ) ? '0 : IdW'(win_idx + 1);
    assign win_green  = req_green_i[win_idx*TIME_W +: TIME_W];
    assign win_red    = req_red_i[win_idx*TIME_W +: TIME_W];
    assign win_yellow = req_yellow_i[win_idx*TIME_W +: TIME_W];

`ifdef TL_CFG_RANGE_CHECK_EN
    function automatic logic time_bad(input logic [TIME_W-1:0] t);
        return (t == '0) || (t > MAX_TIME);
    endfunction

    assign range_bad = time_bad(win_green) || time_bad(win_red) || time_bad(win_yellow);
`else
    logic unused_max_time;
    assign unused_max_time = ^MAX_TIME;
    assign range_bad       = 1'b0;
`endif

    // Next-state, job latching and decoded command outputs.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        green_d     = green_q;
        red_d       = red_q;
        yellow_d    = yellow_q;
        err_d       = 1'b0;
        req_ready_o = '0;
        cmd_valid_o = 1'b0;
        cmd_type_o  = CmdOn;
        cmd_data_o  = '0;
        done_o      = 1'b0;
        busy_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // No grant while reset is asserted: the job would be dropped by the reset.
                if (found && !srst_i) begin
                    req_ready_o[win_idx] = 1'b1;
                    grant_d              = win_id;
                    rr_d                 = next_rr;
                    green_d              = win_green;
                    red_d                = win_red;
                    yellow_d             = win_yellow;
                    if (req_op_i[win_idx]) begin
                        if (range_bad) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = StStby;
                        end
                    end else begin
                        state_d = StOff;
                    end
                end
            end
            StStby: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = CmdStby;
                state_d     = StGrn;
            end
            StGrn: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = CmdGreen;
                cmd_data_o  = green_q;
                state_d     = StRed;
            end
            StRed: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = CmdRed;
                cmd_data_o  = red_q;
                state_d     = StYel;
            end
            StYel: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = CmdYellow;
                cmd_data_o  = yellow_q;
                state_d     = StOn;
            end
            StOn: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = CmdOn;
                done_o      = 1'b1;
                state_d     = StIdle;
            end
            StOff: begin
                cmd_valid_o = 1'b1;
                cmd_type_o  = CmdOff;
                done_o      = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_o = cmd_valid_o;
    end

    // State and job registers; reset abandons any job in flight.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            grant_q  <= '0;
            green_q  <= '0;
            red_q    <= '0;
            yellow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            green_q  <= green_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            err_q    <= err_d;
        end
    end

    assign grant_id_o = grant_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_traffic_lights_cfg_arbiter.sv
// Randomized and directed bench for traffic_lights_cfg_arbiter, checked every cycle
// against a queue-based model of the command stream.
module tb_traffic_lights_cfg_arbiter;

    localparam int N  = 2;
    localparam int TW = 16;
`ifdef TL_CFG_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic            clk;
    logic            srst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_op;
    logic [N*TW-1:0] green;
    logic [N*TW-1:0] red;
    logic [N*TW-1:0] yellow;
    logic [2:0]      cmd_type;
    logic            cmd_valid;
    logic [TW-1:0]   cmd_data;
    logic            busy;
    logic [0:0]      grant_id;
    logic            done;
    logic            err;

    traffic_lights_cfg_arbiter #(
        .NUM_REQ (N),
        .TIME_W  (TW),
        .MAX_TIME(16'd1000)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_green_i (green),
        .req_red_i   (red),
        .req_yellow_i(yellow),
        .cmd_type_o  (cmd_type),
        .cmd_valid_o (cmd_valid),
        .cmd_data_o  (cmd_data),
        .busy_o      (busy),
        .grant_id_o  (grant_id),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    t;
        logic [TW-1:0] d;
        logic          dn;
    } cmd_t;

    int   checks   = 0;
    int   failures = 0;
    cmd_t mq[$];
    int   m_rr     = 0;
    int   m_gid    = 0;
    bit   m_err    = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic set_job(input int i, input bit op, input int g, input int r, input int y);
        req_valid[i]          = 1'b1;
        req_op[i]             = op;
        green[i*TW +: TW]     = TW'(g);
        red[i*TW +: TW]       = TW'(r);
        yellow[i*TW +: TW]    = TW'(y);
    endtask

    function automatic bit bad_time(input logic [TW-1:0] t);
        return (t == 0) || (t > 1000);
    endfunction

    // One cycle: called at a negedge with inputs set; compares, then advances the model.
    task automatic step(output int w);
        logic [N-1:0]  er;
        cmd_t          f;
        logic [TW-1:0] g, r, y;
        #1;
        w  = -1;
        er = '0;
        if (mq.size() == 0 && !srst) begin
            for (int k = 0; k < N; k++) begin
                int ix = (m_rr + k) % N;
                if (w < 0 && req_valid[ix]) w = ix;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        f = (mq.size() > 0) ? mq[0] : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("cmd_valid", 32'(cmd_valid), 32'(mq.size() > 0));
        chk("cmd_type", 32'(cmd_type), 32'(f.t));
        chk("cmd_data", 32'(cmd_data), 32'(f.d));
        chk("done", 32'(done), 32'(f.dn));
        chk("busy", 32'(busy), 32'(mq.size() > 0));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("err", 32'(err), 32'(m_err));

        if (mq.size() > 0) void'(mq.pop_front());
        m_err = 1'b0;
        if (srst) begin
            mq.delete();
            m_rr  = 0;
            m_gid = 0;
        end else if (w >= 0) begin
            m_gid = w;
            m_rr  = (w + 1) % N;
            if (req_op[w]) begin
                g = green[w*TW +: TW];
                r = red[w*TW +: TW];
                y = yellow[w*TW +: TW];
                if (RC && (bad_time(g) || bad_time(r) || bad_time(y))) begin
                    m_err = 1'b1;
                end else begin
                    mq.push_back('{t: 3'd2, d: '0, dn: 1'b0});
                    mq.push_back('{t: 3'd3, d: g, dn: 1'b0});
                    mq.push_back('{t: 3'd4, d: r, dn: 1'b0});
                    mq.push_back('{t: 3'd5, d: y, dn: 1'b0});
                    mq.push_back('{t: 3'd0, d: '0, dn: 1'b1});
                end
            end else begin
                mq.push_back('{t: 3'd1, d: '0, dn: 1'b1});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        int w;
        for (int k = 0; k < n; k++) step(w);
    endtask

    function automatic int rand_time();
        int s = int'($urandom_range(0, 15));
        if (s == 0) return 0;
        if (s == 1) return int'($urandom_range(1001, 65535));
        return int'($urandom_range(1, 1000));
    endfunction

    initial begin
        int w;
        int slot;
        int got1;
        logic [2:0]  exp_t[5];
        logic [15:0] exp_d[5];
        exp_t = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        exp_d = '{16'd0, 16'd40, 16'd60, 16'd20, 16'd0};

        srst      = 1'b1;
        req_valid = '0;
        req_op    = '0;
        green     = '0;
        red       = '0;
        yellow    = '0;
        repeat (3) @(negedge clk);
        step(w);
        srst = 1'b0;

        // Single RUN job from req0.
        set_job(0, 1'b1, 40, 60, 20);
        begin #1; chk("t1_ready", 32'(req_ready), 32'h1); end
        step(w);
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t1_type", 32'(cmd_type), 32'(exp_t[k]));
            chk("t1_data", 32'(cmd_data), 32'(exp_d[k]));
            chk("t1_done", 32'(done), 32'(k == 4));
            chk("t1_busy", 32'(busy), 32'h1);
            step(w);
        end
        begin #1; chk("t1_busy_end", 32'(busy), 32'h0); end
        run(1);

        // Simultaneous RUN jobs from a fresh RR pointer.
        srst = 1'b1;
        step(w);
        srst = 1'b0;
        set_job(0, 1'b1, 11, 12, 13);
        set_job(1, 1'b1, 21, 22, 23);
        step(w);
        req_valid[0] = 1'b0;
        run(5);
        begin #1; chk("t2_ready", 32'(req_ready), 32'h2); end
        step(w);
        req_valid[1] = 1'b0;
        begin
            #1;
            chk("t2_type", 32'(cmd_type), 32'h2);
            chk("t2_gid", 32'(grant_id), 32'h1);
        end
        run(6);

        // req1 OFF followed by req1 RUN.
        set_job(1, 1'b0, 0, 0, 0);
        step(w);
        set_job(1, 1'b1, 100, 200, 300);
        begin
            #1;
            chk("t3_off_type", 32'(cmd_type), 32'h1);
            chk("t3_off_done", 32'(done), 32'h1);
        end
        step(w);
        begin #1; chk("t3_ready", 32'(req_ready), 32'h2); end
        step(w);
        req_valid[1] = 1'b0;
        run(6);

        // Reset during the SET_RED cycle.
        set_job(0, 1'b1, 5, 6, 7);
        step(w);
        req_valid = '0;
        run(2);
        srst = 1'b1;
        begin #1; chk("t4_red", 32'(cmd_type), 32'h4); end
        step(w);
        srst = 1'b0;
        begin
            #1;
            chk("t4_valid", 32'(cmd_valid), 32'h0);
            chk("t4_busy", 32'(busy), 32'h0);
        end
        run(3);
        set_job(0, 1'b1, 1, 2, 3);
        set_job(1, 1'b1, 4, 5, 6);
        begin #1; chk("t4_ready", 32'(req_ready), 32'h1); end
        step(w);
        req_valid = '0;
        run(6);

        // req1 held against continuous req0 traffic.
        slot = 0;
        got1 = -1;
        set_job(0, 1'b1, 9, 9, 9);
        set_job(1, 1'b1, 8, 8, 8);
        for (int k = 0; k < 14; k++) begin
            step(w);
            if (w >= 0) begin
                slot++;
                if (w == 1 && got1 < 0) got1 = slot;
                if (w == 1) req_valid[1] = 1'b0;
            end
        end
        chk("t5_no_starve", 32'(got1 >= 1 && got1 <= 2), 32'h1);
        req_valid = '0;
        run(6);

        // Out-of-range times.
        set_job(0, 1'b1, 40, 0, 20);
        step(w);
        req_valid = '0;
        begin
            #1;
            chk("t6_err", 32'(err), 32'(RC));
            chk("t6_valid", 32'(cmd_valid), 32'(!RC));
        end
        run(6);
        set_job(0, 1'b1, 40, 60, 1001);
        step(w);
        req_valid = '0;
        begin #1; chk("t6_err2", 32'(err), 32'(RC)); end
        run(6);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_job(i, ($urandom_range(0, 3) != 0), rand_time(), rand_time(), rand_time());
                end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            srst = ($urandom_range(0, 199) == 0);
            step(w);
            if (w >= 0) req_valid[w] = 1'b0;
        end
        srst      = 1'b0;
        req_valid = '0;
        run(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
